// File: rtl/fphub_adder_arbiter.sv
// Two-requester round-robin front end for a single FPHUB adder.
// One result slot (EMPTY/FULL) holds the registered sum and the owner id.
// A new pair can be accepted in the same cycle the held result drains.
// The FPHUB adder itself is combinational: operands carry an implicit
// leading one and an implicit trailing half-ulp one. The exact sum is
// truncated, which is round-to-nearest for HUB numbers. Exponent 0 means
// zero. Overflow clamps to the largest finite magnitude. Underflow flushes
// to zero.

module my_FPHUB_adder #(
    parameter int M = 4,
    parameter int E = 4
) (
    input  logic [E+M:0] x,
    input  logic [E+M:0] y,
    output logic [E+M:0] z
);
    // Alignment room covers every possible exponent difference, so the sum is exact
    localparam int EXT  = 32'd1 << E;
    localparam int WS   = M + 32'd3 + EXT;
    localparam int EMAX = (32'd1 << E) - 32'd1;

    logic          x_big_s;
    logic [E+M:0]  a_s;
    logic [E+M:0]  b_s;
    logic [M+1:0]  sig_a_s;
    logic [M+1:0]  sig_b_s;
    logic [WS-1:0] wa_s;
    logic [WS-1:0] wb_s;
    logic [WS-1:0] sum_s;
    int            p_s;
    int            er_s;

    // Order by magnitude, align the exact significands, add, then normalise and truncate
    always_comb begin
        x_big_s = (x[E+M-1:0] >= y[E+M-1:0]);
        a_s     = x_big_s ? x : y;
        b_s     = x_big_s ? y : x;
        if (a_s[E+M-1:M] == '0) begin
            sig_a_s = '0;
        end else begin
            sig_a_s = {1'b1, a_s[M-1:0], 1'b1};
        end
        if (b_s[E+M-1:M] == '0) begin
            sig_b_s = '0;
        end else begin
            sig_b_s = {1'b1, b_s[M-1:0], 1'b1};
        end
        wa_s = WS'(sig_a_s) << EXT;
        wb_s = (WS'(sig_b_s) << EXT) >> (a_s[E+M-1:M] - b_s[E+M-1:M]);
        if (a_s[E+M] == b_s[E+M]) begin
            sum_s = wa_s + wb_s;
        end else begin
            sum_s = wa_s - wb_s;
        end
        p_s = 32'd0;
        for (int i = 0; i < WS; i++) begin
            p_s = sum_s[i] ? i : p_s;
        end
        er_s = int'(a_s[E+M-1:M]) + p_s - (M + 32'd1 + EXT);
        if ((sum_s == '0) || (er_s <= 32'sd0)) begin
            z = '0;
        end else if (er_s > EMAX) begin
            z = {a_s[E+M], {E{1'b1}}, {M{1'b1}}};
        end else begin
            z = {a_s[E+M], er_s[E-1:0], M'((sum_s << (WS - 32'd1 - p_s)) >> (WS - 32'd1 - M))};
        end
    end
endmodule

module fphub_adder_arbiter #(
    parameter int M = 4,
    parameter int E = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [E+M:0] req0_x,
    input  logic [E+M:0] req0_y,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [E+M:0] req1_x,
    input  logic [E+M:0] req1_y,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [E+M:0] res_z,
    output logic         res_id,
    output logic [15:0]  ops_done
);
    localparam int W = E + M + 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t  state_r;
    logic         last_grant_r;
    logic [W-1:0] res_z_r;
    logic         res_id_r;
    logic [15:0]  ops_done_r;

    logic         grant_s;
    logic         slot_free_s;
    logic         accept_s;
    logic         drain_s;
    logic [W-1:0] add_x_s;
    logic [W-1:0] add_y_s;
    logic [W-1:0] add_z_s;

    // Round-robin grant, slot availability, readies and the adder operand mux
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant_s = ~last_grant_r;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        slot_free_s = (state_r == EMPTY) || res_ready;
        req0_ready  = slot_free_s && !grant_s;
        req1_ready  = slot_free_s && grant_s;
        if (grant_s) begin
            accept_s = req1_valid && req1_ready;
            add_x_s  = req1_x;
            add_y_s  = req1_y;
        end else begin
            accept_s = req0_valid && req0_ready;
            add_x_s  = req0_x;
            add_y_s  = req0_y;
        end
        drain_s = (state_r == FULL) && res_ready;
    end

    my_FPHUB_adder #(.M(M), .E(E)) u_adder (
        .x (add_x_s),
        .y (add_y_s),
        .z (add_z_s)
    );

    // Result slot: load on accept (even while draining), empty on drain alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= EMPTY;
            last_grant_r <= 1'b1;
            res_z_r      <= '0;
            res_id_r     <= 1'b0;
        end else if (accept_s) begin
            state_r      <= FULL;
            last_grant_r <= grant_s;
            res_z_r      <= add_z_s;
            res_id_r     <= grant_s;
        end else if (drain_s) begin
            state_r      <= EMPTY;
        end else begin
            state_r      <= state_r;
        end
    end

    // Saturating count of completed result handshakes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_done_r <= 16'd0;
        end else if (drain_s && (ops_done_r != 16'hFFFF)) begin
            ops_done_r <= ops_done_r + 16'd1;
        end else begin
            ops_done_r <= ops_done_r;
        end
    end

    assign res_valid = (state_r == FULL);
    assign res_z     = res_z_r;
    assign res_id    = res_id_r;
    assign ops_done  = ops_done_r;
endmodule

// File: tb/tb_fphub_adder_arbiter.sv
// Scoreboard bench for fphub_adder_arbiter: a protocol/value model pushes
// expected results on every accept, a monitor pops and compares on every
// result handshake. Sums come from real-valued FPHUB arithmetic.

module tb_fphub_adder_arbiter;
    localparam int M    = 4;
    localparam int E    = 4;
    localparam int W    = E + M + 1;
    localparam int BIAS = (1 << (E - 1)) - 1;
    localparam int EMAX = (1 << E) - 1;

    typedef struct {
        logic [W-1:0] z;
        logic         id;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0;
    logic         req0_ready;
    logic [W-1:0] req0_x = '0;
    logic [W-1:0] req0_y = '0;
    logic         req1_valid = 1'b0;
    logic         req1_ready;
    logic [W-1:0] req1_x = '0;
    logic [W-1:0] req1_y = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_z;
    logic         res_id;
    logic [15:0]  ops_done;

    exp_t         sb_q[$];
    bit           id_log[$];
    int           errors = 0;
    int           checks = 0;
    bit           exp_full = 1'b0;
    bit           exp_last = 1'b1;
    int           exp_ops = 0;
    bit           acc0 = 1'b0;
    bit           acc1 = 1'b0;
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_z = '0;
    logic         prev_id = 1'b0;
    logic [W-1:0] held_z;

    fphub_adder_arbiter #(.M(M), .E(E)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_z      (res_z),
        .res_id     (res_id),
        .ops_done   (ops_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Real value of an FPHUB word: (1.m + half ulp) * 2^(e-bias), exponent 0 is zero
    function automatic real hub_val(input logic [W-1:0] v);
        real s;
        int  e;
        e = int'(v[W-2:M]);
        if (e == 0) return 0.0;
        s = 1.0 + real'(int'(v[M-1:0])) / real'(1 << M) + 1.0 / real'(1 << (M + 1));
        for (int i = 0; i < e - BIAS; i++) s = s * 2.0;
        for (int i = 0; i < BIAS - e; i++) s = s / 2.0;
        return v[W-1] ? -s : s;
    endfunction

    // Nearest HUB word: truncate the magnitude's fraction to M bits
    function automatic logic [W-1:0] hub_enc(input real r);
        real  mag;
        real  scale;
        int   k;
        int   er;
        int   mant;
        logic sgn;
        if (r == 0.0) return '0;
        sgn   = (r < 0.0);
        mag   = sgn ? -r : r;
        scale = 1.0;
        k     = 0;
        while (mag >= 2.0 * scale) begin scale = scale * 2.0; k++; end
        while (mag < scale) begin scale = scale / 2.0; k--; end
        er = k + BIAS;
        if (er <= 0) return '0;
        if (er > EMAX) return {sgn, {E{1'b1}}, {M{1'b1}}};
        mant = $rtoi((mag / scale - 1.0) * real'(1 << M));
        return {sgn, E'(er), M'(mant)};
    endfunction

    task automatic clear_model();
        sb_q.delete();
        id_log.delete();
        exp_full   = 1'b0;
        exp_last   = 1'b1;
        exp_ops    = 0;
        acc0       = 1'b0;
        acc1       = 1'b0;
        prev_stall = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise/keep valids; a requester only changes operands after its pair was taken
    task automatic present(input bit v0, input bit v1);
        if (!req0_valid || acc0) begin
            req0_x = W'($urandom);
            req0_y = W'($urandom);
        end
        if (!req1_valid || acc1) begin
            req1_x = W'($urandom);
            req1_y = W'($urandom);
        end
        req0_valid = v0;
        req1_valid = v1;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        clear_model();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b0;
        tick();
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_ops", 32'(ops_done), 32'd0);
        chk("rst_z", 32'(res_z), 32'd0);
        chk("rst_id", 32'(res_id), 32'd0);
        tick();
        rst_n = 1'b1;
    endtask

    // Reference model: grant/ready/slot protocol and expected results pushed on accept
    always @(negedge clk) begin
        bit g;
        bit free;
        if (rst_n) begin
            g    = (req0_valid && req1_valid) ? ~exp_last : req1_valid;
            free = !exp_full || res_ready;
            chk("res_valid", 32'(res_valid), 32'(exp_full));
            chk("ops_done", 32'(ops_done), 32'(exp_ops));
            if (req0_valid || req1_valid) begin
                chk("req0_ready", 32'(req0_ready), 32'(free && !g));
                chk("req1_ready", 32'(req1_ready), 32'(free && g));
            end
            chk("one_ready", 32'(req0_ready && req1_ready), 32'd0);
            acc0 = free && !g && req0_valid;
            acc1 = free && g && req1_valid;
            if (exp_full && res_ready && exp_ops < 65535) exp_ops++;
            if (acc0 || acc1) begin
                if (g) sb_q.push_back('{hub_enc(hub_val(req1_x) + hub_val(req1_y)), 1'b1});
                else   sb_q.push_back('{hub_enc(hub_val(req0_x) + hub_val(req0_y)), 1'b0});
                exp_last = g;
                exp_full = 1'b1;
            end else if (exp_full && res_ready) begin
                exp_full = 1'b0;
            end
        end
    end

    // Monitor: compare every result handshake against the scoreboard, check hold while stalled
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (prev_stall) begin
                chk("hold_valid", 32'(res_valid), 32'd1);
                chk("hold_z", 32'(res_z), 32'(prev_z));
                chk("hold_id", 32'(res_id), 32'(prev_id));
            end
            if (res_valid && res_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_nonempty", 32'd0, 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk("res_z", 32'(res_z), 32'(e.z));
                    chk("res_id", 32'(res_id), 32'(e.id));
                end
                id_log.push_back(res_id);
            end
            prev_stall = res_valid && !res_ready;
            prev_z     = res_z;
            prev_id    = res_id;
        end
    end

    initial begin
        // Single pair from requester 0 with a known sum
        do_reset();
        req0_x = 9'h0A3; req0_y = 9'h091; req0_valid = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        chk("t1_ready0", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("t1_valid", 32'(res_valid), 32'd1);
        chk("t1_id", 32'(res_id), 32'd0);
        chk("t1_z", 32'(res_z), 32'h0AC);
        tick();

        // Both requesters continuously: strict alternation, one result per cycle
        do_reset();
        res_ready = 1'b1;
        repeat (6) begin present(1'b1, 1'b1); tick(); end
        present(1'b0, 1'b0);
        tick();
        @(negedge clk);
        chk("rr_ops", 32'(ops_done), 32'd6);
        chk("rr_count", 32'(id_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < id_log.size(); i++) chk("rr_id", 32'(id_log[i]), 32'(i % 2));

        // Stall for 5 cycles, then drain and accept in the same cycle
        do_reset();
        res_ready = 1'b0;
        present(1'b1, 1'b1);
        tick();
        held_z = res_z;
        repeat (5) begin
            present(1'b1, 1'b1);
            @(negedge clk);
            chk("st_ready0", 32'(req0_ready), 32'd0);
            chk("st_ready1", 32'(req1_ready), 32'd0);
            tick();
        end
        chk("st_z", 32'(res_z), 32'(held_z));
        res_ready = 1'b1;
        present(1'b1, 1'b1);
        @(negedge clk);
        chk("st_ready1_up", 32'(req1_ready), 32'd1);
        tick();
        present(1'b0, 1'b0);
        @(negedge clk);
        chk("st_ops", 32'(ops_done), 32'd1);
        chk("st_full", 32'(res_valid), 32'd1);
        chk("st_id", 32'(res_id), 32'd1);
        tick();

        // Requester 1 alone three times, then both: requester 0 wins
        do_reset();
        res_ready = 1'b1;
        repeat (3) begin present(1'b0, 1'b1); tick(); end
        present(1'b1, 1'b1);
        tick();
        present(1'b0, 1'b0);
        tick();
        @(negedge clk);
        chk("solo_count", 32'(id_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < id_log.size(); i++) chk("solo_id", 32'(id_log[i]), 32'(i < 3));

        // Counter saturation
        do_reset();
        res_ready = 1'b1;
        repeat (65537) begin present(1'b1, 1'b0); tick(); end
        present(1'b0, 1'b0);
        tick();
        @(negedge clk);
        chk("sat_ops", 32'(ops_done), 32'hFFFF);

        // Asynchronous reset while FULL, then grant order after release
        do_reset();
        res_ready = 1'b0;
        present(1'b1, 1'b0);
        tick();
        present(1'b0, 1'b0);
        #2;
        chk("ar_full", 32'(res_valid), 32'd1);
        rst_n = 1'b0;
        clear_model();
        #1;
        chk("ar_valid", 32'(res_valid), 32'd0);
        chk("ar_z", 32'(res_z), 32'd0);
        chk("ar_id", 32'(res_id), 32'd0);
        chk("ar_ops", 32'(ops_done), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        res_ready = 1'b1;
        present(1'b1, 1'b1);
        @(negedge clk);
        chk("ar_ready0", 32'(req0_ready), 32'd1);
        chk("ar_ready1", 32'(req1_ready), 32'd0);
        tick();
        present(1'b0, 1'b0);
        tick();
        @(negedge clk);
        chk("ar_first_id", 32'(id_log.size() > 0 ? id_log[0] : 1'b1), 32'd0);

        // Random traffic with random back-pressure
        do_reset();
        repeat (600) begin
            present(1'($urandom), 1'($urandom));
            res_ready = ($urandom_range(3) != 0);
            tick();
        end
        present(1'b0, 1'b0);
        res_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
